// File: rtl/maj_eval_pkg.sv
// Shared types and helpers for the majority-gate network evaluator.
package maj_eval_pkg;

  localparam int PKG_IDW     = 4;
  localparam int NODE_CONST0 = 0;

  typedef logic [PKG_IDW-1:0] node_idx_t;

  // Bit layout matches cfg_data: a lowest, inversion flags on top.
  typedef struct packed {
    logic      ic;
    logic      ib;
    logic      ia;
    node_idx_t c;
    node_idx_t b;
    node_idx_t a;
  } gate_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maj_eval_nodefile.sv
// Node value storage: node 0 is constant 0, PI nodes load as a block,
// gate nodes are written one per cycle. Three combinational read ports.
module maj_eval_nodefile #(
  parameter int NUM_PI   = 4,
  parameter int NUM_NODE = 13,
  parameter int IDW      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pi_load,
  input  logic [NUM_PI-1:0]   pi,
  input  logic                we,
  input  logic [IDW-1:0]      waddr,
  input  logic                wdata,
  input  logic [IDW-1:0]      raddr_a,
  input  logic [IDW-1:0]      raddr_b,
  input  logic [IDW-1:0]      raddr_c,
  output logic                rdata_a,
  output logic                rdata_b,
  output logic                rdata_c,
  output logic [NUM_NODE-1:0] node_vec
);

  logic [NUM_NODE-1:0] nodes;

  // Indices beyond the node range read as 0.
  function automatic logic pick(input logic [NUM_NODE-1:0] v, input logic [IDW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_NODE; i++)
      if (idx == IDW'(i)) r = v[i];
    return r;
  endfunction

  // Node registers; node 0 is only ever written by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nodes <= '0;
    end else begin
      if (pi_load) nodes[NUM_PI:1] <= pi;
      for (int i = NUM_PI + 1; i < NUM_NODE; i++)
        if (we && waddr == IDW'(i)) nodes[i] <= wdata;
    end
  end

  assign rdata_a  = pick(nodes, raddr_a);
  assign rdata_b  = pick(nodes, raddr_b);
  assign rdata_c  = pick(nodes, raddr_c);
  assign node_vec = nodes;

endmodule

// File: rtl/maj_net_eval.sv
// Majority-gate network evaluator: runs a programmed list of MAJ gates,
// one per cycle, over a latched input vector and presents mapped outputs.
// Optional feature macro: MAJ_EVAL_CNT_EN adds the eval_cnt output.
//
// state | meaning
// IDLE  | ready for a vector, cfg writes applied
// EVAL  | evaluating gate cnt this cycle
// HOLD  | result registered/held until out_ready
module maj_net_eval
  import maj_eval_pkg::*;
#(
  parameter int NUM_PI   = 4,
  parameter int NUM_GATE = 8,
  parameter int NUM_PO   = 2,
  parameter int IDW      = 4,
  localparam int GAW     = (NUM_GATE > 1) ? $clog2(NUM_GATE) : 1,
  localparam int PAW     = (NUM_PO > 1) ? $clog2(NUM_PO) : 1,
  localparam int GW      = 3 * IDW + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [GAW-1:0]    cfg_addr,
  input  logic [GW-1:0]     cfg_data,
  input  logic              cfg_po_we,
  input  logic [PAW-1:0]    cfg_po_idx,
  input  logic [IDW-1:0]    cfg_po_node,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_PI-1:0] in_pi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_PO-1:0] out_po,
  output logic [1:0]        err,
  output logic              busy
`ifdef MAJ_EVAL_CNT_EN
  ,
  output logic [15:0]       eval_cnt
`endif
);

  localparam int NUM_NODE = 1 + NUM_PI + NUM_GATE;

  state_t              state, state_nx;
  logic [GAW-1:0]      cnt;
  logic [GW-1:0]       prog [NUM_GATE];
  logic [IDW-1:0]      po_map [NUM_PO];
  logic [NUM_NODE-1:0] node_vec;
  logic [GW-1:0]       cur;
  logic [IDW-1:0]      idx_a, idx_b, idx_c;
  logic [2:0]          inv;
  logic                rd_a, rd_b, rd_c;
  logic                ok_a, ok_b, ok_c;
  logic                gate_val, gate_bad;
  logic [IDW-1:0]      wr_idx;
  logic [NUM_PO-1:0]   po_vals;
  logic                accept, last_gate, exit_hold;
  int                  lim;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign last_gate = (int'(cnt) == NUM_GATE - 1);
  assign exit_hold = (state == ST_HOLD) & out_valid & out_ready;

  // Decode the gate being evaluated; only nodes strictly before it are legal operands.
  assign cur    = prog[cnt];
  assign idx_a  = cur[IDW-1:0];
  assign idx_b  = cur[2*IDW-1:IDW];
  assign idx_c  = cur[3*IDW-1:2*IDW];
  assign inv    = cur[GW-1:3*IDW];
  assign lim    = NUM_PI + 1 + int'(cnt);
  assign ok_a   = int'(idx_a) < lim;
  assign ok_b   = int'(idx_b) < lim;
  assign ok_c   = int'(idx_c) < lim;
  assign gate_val = maj3((ok_a & rd_a) ^ inv[0], (ok_b & rd_b) ^ inv[1], (ok_c & rd_c) ^ inv[2]);
  assign gate_bad = ~(ok_a & ok_b & ok_c);
  assign wr_idx   = IDW'(NUM_PI + 1) + IDW'(cnt);

  maj_eval_nodefile #(
    .NUM_PI  (NUM_PI),
    .NUM_NODE(NUM_NODE),
    .IDW     (IDW)
  ) u_nodes (
    .clk     (clk),
    .rst_n   (rst_n),
    .pi_load (accept),
    .pi      (in_pi),
    .we      (state == ST_EVAL),
    .waddr   (wr_idx),
    .wdata   (gate_val),
    .raddr_a (idx_a),
    .raddr_b (idx_b),
    .raddr_c (idx_c),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_c (rd_c),
    .node_vec(node_vec)
  );

  // Output-map lookup; unmapped/out-of-range node indices read 0.
  always_comb begin
    po_vals = '0;
    for (int p = 0; p < NUM_PO; p++)
      for (int i = 0; i < NUM_NODE; i++)
        if (po_map[p] == IDW'(i)) po_vals[p] = node_vec[i];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)    state_nx = ST_EVAL;
      ST_EVAL: if (last_gate) state_nx = ST_HOLD;
      ST_HOLD: if (exit_hold) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Program/map storage, gate counter, result and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_po    <= '0;
      err       <= 2'b00;
      for (int g = 0; g < NUM_GATE; g++) prog[g] <= '0;
      for (int p = 0; p < NUM_PO; p++) po_map[p] <= IDW'(NODE_CONST0);
    end else begin
      if (cfg_we) begin
        if (state == ST_IDLE && int'(cfg_addr) < NUM_GATE) prog[cfg_addr] <= cfg_data;
        else                                               err[1] <= 1'b1;
      end
      if (cfg_po_we) begin
        if (state == ST_IDLE && int'(cfg_po_idx) < NUM_PO) po_map[cfg_po_idx] <= cfg_po_node;
        else                                               err[1] <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err[0] <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_EVAL: begin
          if (gate_bad)   err[0] <= 1'b1;
          if (!last_gate) cnt <= cnt + GAW'(1);
        end
        ST_HOLD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_po    <= po_vals;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAJ_EVAL_CNT_EN
  // Saturating count of completed (consumed) evaluations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               eval_cnt <= 16'h0000;
    else if (exit_hold && eval_cnt != 16'hFFFF) eval_cnt <= eval_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_maj_net_eval.sv
// Self-checking bench for maj_net_eval with a node-array reference model.
module tb_maj_net_eval;

  localparam int NG = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [14:0] cfg_data = '0;
  logic        cfg_po_we = 1'b0;
  logic [0:0]  cfg_po_idx = '0;
  logic [3:0]  cfg_po_node = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_pi = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_po;
  logic [1:0]  err;
  logic        busy;
`ifdef MAJ_EVAL_CNT_EN
  logic [15:0] eval_cnt;
`endif

  maj_net_eval dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_po_we  (cfg_po_we),
    .cfg_po_idx (cfg_po_idx),
    .cfg_po_node(cfg_po_node),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pi      (in_pi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_po     (out_po),
    .err        (err),
    .busy       (busy)
`ifdef MAJ_EVAL_CNT_EN
    ,
    .eval_cnt   (eval_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // reference model state
  int ma [NG], mb [NG], mc [NG], mia [NG], mib [NG], mic [NG];
  int mpo [2];
  int exp_po = 0, exp_err0 = 0, exp_err1 = 0;
  int pend_g = 0, pend_d = 0;
  int last_po = 0, last_err = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int g = 0; g < NG; g++) begin
      ma[g] = 0; mb[g] = 0; mc[g] = 0; mia[g] = 0; mib[g] = 0; mic[g] = 0;
    end
    mpo[0] = 0; mpo[1] = 0;
  endtask

  task automatic apply_cfg(input int g, input int d);
    ma[g]  = d & 15;
    mb[g]  = (d >> 4) & 15;
    mc[g]  = (d >> 8) & 15;
    mia[g] = (d >> 12) & 1;
    mib[g] = (d >> 13) & 1;
    mic[g] = (d >> 14) & 1;
  endtask

  // Evaluate the whole program: node n = value, illegal operands read 0.
  task automatic model_eval(input int pi, output int po, output int e0);
    int node [16];
    int idx [3];
    int inv [3];
    int s, v;
    e0 = 0;
    po = 0;
    for (int i = 0; i < 16; i++) node[i] = 0;
    for (int i = 0; i < 4; i++) node[1+i] = (pi >> i) & 1;
    for (int g = 0; g < NG; g++) begin
      idx[0] = ma[g]; idx[1] = mb[g]; idx[2] = mc[g];
      inv[0] = mia[g]; inv[1] = mib[g]; inv[2] = mic[g];
      s = 0;
      for (int k = 0; k < 3; k++) begin
        if (idx[k] < 5 + g) v = node[idx[k]];
        else begin
          v  = 0;
          e0 = 1;
        end
        s += v ^ inv[k];
      end
      node[5+g] = (s >= 2) ? 1 : 0;
    end
    for (int p = 0; p < 2; p++) po |= node[mpo[p]] << p;
  endtask

  task automatic cfg_gate(input int g, input int a, input int b, input int c,
                          input int ia, input int ib, input int ic);
    int d;
    d = a | (b << 4) | (c << 8) | (ia << 12) | (ib << 13) | (ic << 14);
    cfg_we = 1'b1; cfg_addr = 3'(g); cfg_data = 15'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    apply_cfg(g, d);
  endtask

  task automatic cfg_po(input int p, input int n);
    cfg_po_we = 1'b1; cfg_po_idx = 1'(p); cfg_po_node = 4'(n);
    @(posedge clk); #1;
    cfg_po_we = 1'b0;
    mpo[p] = n;
  endtask

  // mode 0: plain; 1: cfg write of pend_g/pend_d with the accept; 2: cfg write during EVAL
  task automatic run_vec(input int pi, input int hold, input bit ov, input int mode);
    int k, po_e, e0_e;
    in_valid = 1'b1;
    in_pi    = 4'(pi);
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_addr = 3'(pend_g); cfg_data = 15'(pend_d);
      apply_cfg(pend_g, pend_d);
    end
    model_eval(pi, po_e, e0_e);
    exp_po   = po_e;
    exp_err0 = e0_e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (mode == 2 && k == 3) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 15'h7000;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (mode == 2 && k == 3) exp_err1 = 1;
      if (out_valid) break;
    end
    chk("latency", k, NG + 1);
    last_po  = int'(out_po);
    last_err = int'(err);
    for (int h = 0; h < hold; h++) begin
      in_valid = ov;
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
    end
    in_valid  = ov;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("exit_valid", int'(out_valid), 0);
    chk("exit_busy", int'(busy), 0);
  endtask

  // Per-cycle compare against the model while a result is presented.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("err1", int'(err[1]), exp_err1);
      if (out_valid) begin
        chk("po", int'(out_po), exp_po);
        chk("err0", int'(err[0]), exp_err0);
        chk("in_ready_hold", int'(in_ready), 0);
      end
    end
  end

  initial begin
    int r0, seen;
    model_clear();
    rst_n = 1'b0;
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_po", int'(out_po), 0);
    chk("rst_err", int'(err), 0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // MAJ(n1,n2,n3) on PO0
    cfg_gate(0, 1, 2, 3, 0, 0, 0);
    cfg_po(0, 5);
    run_vec(4'b0011, 0, 0, 0);
    chk("lit_maj_po0", last_po & 1, 1);
    chk("lit_maj_err", last_err, 0);

    // OR via MAJ(~n0,n1,n2) on PO1
    cfg_gate(0, 0, 1, 2, 1, 0, 0);
    cfg_po(1, 5);
    run_vec(4'b0000, 0, 0, 0);
    chk("lit_or0_po1", (last_po >> 1) & 1, 0);
    run_vec(4'b0001, 0, 0, 0);
    chk("lit_or1_po1", (last_po >> 1) & 1, 1);

    // forward operand reads 0 and flags err0; clean vector clears it
    cfg_gate(0, 6, 1, 2, 0, 0, 0);
    run_vec(4'b0011, 0, 0, 0);
    chk("lit_fwd_err0", last_err & 1, 1);
    chk("lit_fwd_po0", last_po & 1, 1);
    cfg_gate(0, 1, 2, 3, 0, 0, 0);
    run_vec(4'b0000, 0, 0, 0);
    chk("lit_clean_err0", last_err & 1, 0);

    // long hold with a competing vector offered
    run_vec(4'b0101, 5, 1, 0);
    run_vec(4'b0110, 0, 0, 0);

    // cfg write during EVAL is dropped; replay matches
    run_vec(4'b0000, 0, 0, 0);
    r0 = last_po;
    run_vec(4'b0000, 0, 0, 2);
    chk("drop_replay", last_po, r0);
    chk("lit_drop_po", last_po, 0);
    chk("lit_drop_err1", int'(err[1]), 1);

    // cfg write in the accept cycle takes effect for that vector
    cfg_po(0, 6);
    pend_g = 1;
    pend_d = 5 | (1 << 13);
    run_vec(4'b0011, 0, 0, 1);
    chk("lit_cfg_first", last_po & 1, 1);

    // randomized program/vectors
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_gate($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cfg_po($urandom_range(0, 1), $urandom_range(0, 15));
      pend_g = $urandom_range(0, 7);
      pend_d = $urandom_range(0, 32767);
      run_vec($urandom_range(0, 15), $urandom_range(0, 3), 0, $urandom_range(0, 2));
    end

    // reset while evaluating gate 3
    cfg_gate(0, 1, 2, 3, 0, 0, 0);
    cfg_po(0, 5);
    in_valid = 1'b1; in_pi = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_eval_busy", int'(busy), 1);
    rst_n    = 1'b0;
    exp_err1 = 0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_err", int'(err), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("no_valid_pulse", seen, 0);
    @(posedge clk); #1;
    run_vec(4'hF, 0, 0, 0);
    chk("lit_cleared_po", last_po, 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
